// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the pipelined RV32I datapath stage registers.
// Holds the {s_vld, m_vld} state encoding and the packed stage-bundle widths.
package riscv_pipe_pkg;

  localparam int unsigned XLEN = 32;

  // Stage state is the pair of valid bits {s_vld, m_vld}.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_FULL  = 2'b01;
  localparam logic [1:0] ST_BAD   = 2'b10;
  localparam logic [1:0] ST_SKID  = 2'b11;

  typedef enum logic [1:0] {
    StEmpty = ST_EMPTY,
    StFull  = ST_FULL,
    StBad   = ST_BAD,
    StSkid  = ST_SKID
  } pipe_state_e;

  // Packed bundle widths per pipeline boundary.
  localparam int unsigned IFID_W  = 2 * XLEN;             // pc, instr
  localparam int unsigned IDEX_W  = 4 * XLEN + 5 + 16;    // pc, rs1, rs2, imm, rd, ctrl
  localparam int unsigned EXMEM_W = 2 * XLEN + 5 + 8;     // alu, store data, rd, ctrl
  localparam int unsigned MEMWB_W = XLEN + 5 + 2;         // wb data, rd, ctrl

endpackage

// File: rtl/flopenr.sv
// Enable flop with asynchronous active-low reset and synchronous clear.
// Clear takes priority over enable; both load RESET_VAL / d respectively.
module flopenr #(
  parameter int unsigned W         = 32,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RESET_VAL;
    end else if (clr) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, sync flush and one-entry skid buffer.
// in_ready comes straight from state flops, so downstream stalls never ripple combinationally upstream.
module pipe_stage_skid
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned W         = 32,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  pipe_state_e  state_q, state_d;
  logic         m_load, s_load, m_from_skid;
  logic         in_xfer, out_xfer;
  logic [W-1:0] m_data, s_data, m_data_d;

  assign in_ready  = reset_n & ~state_q[1];
  assign out_valid = state_q[0];
  assign out_data  = m_data;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    m_load      = 1'b0;
    s_load      = 1'b0;
    m_from_skid = 1'b0;
    case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          m_load  = 1'b1;
          state_d = StFull;
        end
      end
      StFull: begin
        if (in_xfer && out_xfer) begin
          m_load = 1'b1;
        end else if (out_xfer) begin
          state_d = StEmpty;
        end else if (in_xfer) begin
          s_load  = 1'b1;
          state_d = StSkid;
        end
      end
      StSkid: begin
        if (out_xfer) begin
          m_load      = 1'b1;
          m_from_skid = 1'b1;
          state_d     = StFull;
        end
      end
      StBad:   state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
    // Flush wins over any handshake; a concurrent in transfer is dropped.
    if (flush) begin
      state_d = StEmpty;
      m_load  = 1'b0;
      s_load  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  assign m_data_d = m_from_skid ? s_data : in_data;

  flopenr #(
    .W         (W),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (m_load),
    .clr     (flush),
    .d       (m_data_d),
    .q       (m_data)
  );

  flopenr #(
    .W         (W),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (s_load),
    .clr     (flush),
    .d       (in_data),
    .q       (s_data)
  );

  // Skid-only occupancy ({s_vld, m_vld} = 10) can never be entered.
  a_no_bad_state: assert property (@(posedge clk) disable iff (!reset_n) state_q != StBad);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random valid/ready traffic,
// all compared against a queue model of an up-to-two-entry FIFO stage.
module tb_pipe_stage_skid;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] model_q[$];
  logic [W-1:0] seen_q[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .W         (W),
    .RESET_VAL ('0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs to the model, then advance the model at the edge.
  task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    bit in_acc, out_acc;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, model_q.size() > 0});
    chk("in_ready", {31'b0, in_ready}, {31'b0, model_q.size() < 2});
    if (model_q.size() > 0) chk("out_data", out_data, model_q[0]);
    in_acc  = iv && (model_q.size() < 2);
    out_acc = ordy && (model_q.size() > 0);
    if (out_valid && ordy) seen_q.push_back(out_data);
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (out_acc) void'(model_q.pop_front());
      if (in_acc) model_q.push_back(d);
    end
    #1;
  endtask

  initial begin
    logic [W-1:0] exp_skid[3];
    exp_skid[0] = 32'hA;
    exp_skid[1] = 32'hB;
    exp_skid[2] = 32'hC;

    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, '0);
    chk("rst_in_ready", {31'b0, in_ready}, '0);
    chk("rst_out_data", out_data, '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) cycle(1'b1, W'(i), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("stream_count", W'(seen_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("stream_order", seen_q[i], W'(i + 1));
    seen_q.delete();

    // Fill main and skid while stalled; the third beat must wait upstream.
    cycle(1'b1, 32'hA, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0);
    chk("skid_in_ready", {31'b0, in_ready}, '0);
    cycle(1'b1, 32'hC, 1'b0, 1'b0);
    cycle(1'b1, 32'hC, 1'b1, 1'b0);
    cycle(1'b1, 32'hC, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("skid_count", W'(seen_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("skid_order", seen_q[i], exp_skid[i]);
    seen_q.delete();

    // Flush while full of two beats, with a new beat offered at the same edge.
    cycle(1'b1, 32'h1, 1'b0, 1'b0);
    cycle(1'b1, 32'h2, 1'b0, 1'b0);
    cycle(1'b1, 32'hD, 1'b0, 1'b1);
    chk("flush_out_valid", {31'b0, out_valid}, '0);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    chk("flush_out_data", out_data, '0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("flush_nothing_out", W'(seen_q.size()), '0);

    // Asynchronous reset with both entries occupied, observed before any edge.
    cycle(1'b1, 32'h5, 1'b0, 1'b0);
    cycle(1'b1, 32'h6, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, '0);
    chk("arst_in_ready", {31'b0, in_ready}, '0);
    chk("arst_out_data", out_data, '0);
    model_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle(1'b1, 32'h77, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    seen_q.delete();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 64) == 0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty", {31'b0, out_valid}, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
